// File: rtl/up_state_pkg.sv
// Shared state encodings and constants for the uP state controller.
// Define UP_STATE_CHECKSUM_EN to build the boot image checksum check.
package up_state_pkg;

  localparam int IDX_W  = 16;
  localparam int DATA_W = 16;
  localparam int CSUM_W = 16;

`ifdef UP_STATE_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // Values 0..7 are the reported encodings; CHECK and ERROR are internal only.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_BOOT_RD   = 4'd1,
    ST_BOOT_WAIT = 4'd2,
    ST_BOOT_WR   = 4'd3,
    ST_RUN       = 4'd4,
    ST_PAUSING   = 4'd5,
    ST_PAUSED    = 4'd6,
    ST_RESUMING  = 4'd7,
    ST_CHECK     = 4'd8,
    ST_ERROR     = 4'd9
  } up_state_e;

  // CHECK still looks like boot-in-progress; ERROR reads as IDLE with o_bootErr set.
  function automatic logic [2:0] report_state(input up_state_e s);
    logic [3:0] sv;
    logic [2:0] r;
    sv = s;
    case (s)
      ST_CHECK: r = 3'd2;
      ST_ERROR: r = 3'd0;
      default:  r = sv[2:0];
    endcase
    return r;
  endfunction

  function automatic logic core_released(input up_state_e s);
    return (s == ST_RUN) || (s == ST_PAUSING) ||
           (s == ST_PAUSED) || (s == ST_RESUMING);
  endfunction

  function automatic logic pause_held(input up_state_e s);
    return (s == ST_PAUSING) || (s == ST_PAUSED);
  endfunction

endpackage

// File: rtl/up_boot_copier.sv
// Boot copy datapath: word index, ROM read / memory write strobes and the
// optional running checksum (UP_STATE_CHECKSUM_EN). Sequenced by up_state_ctrl.
module up_boot_copier
  import up_state_pkg::*;
#(
  parameter int BOOT_WORDS = 32768
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_go_i,
  input  logic              cap_i,
  input  logic              wr_go_i,
  input  logic              inc_i,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [IDX_W-1:0]  rom_addr_o,
  output logic              rom_rd_o,
  output logic [IDX_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wr_o,
  output logic              last_word_o,
  output logic              chk_idx_o,
  output logic              chk_ok_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BOOT_WORDS - 1);
  localparam logic [IDX_W-1:0] CHK_IDX  = IDX_W'(BOOT_WORDS);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rom_addr_q, rom_addr_d;
  logic              rom_rd_q, rom_rd_d;
  logic [IDX_W-1:0]  mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // The read address is taken from the post-increment index so that the
  // BOOT_WR -> BOOT_RD transition already presents the next word.
  always_comb begin
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    if (inc_i) begin
      idx_d = idx_q + 1'b1;
    end
    rom_rd_d = rd_go_i;
    if (rd_go_i) begin
      rom_addr_d = idx_d;
    end
    if (cap_i) begin
      data_d = rom_data_i;
    end
    mem_wr_d = wr_go_i;
    if (wr_go_i) begin
      mem_addr_d = {1'b0, idx_q[IDX_W-2:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wr_q   <= 1'b0;
      data_q     <= '0;
    end else begin
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      rom_rd_q   <= rom_rd_d;
      mem_addr_q <= mem_addr_d;
      mem_wr_q   <= mem_wr_d;
      data_q     <= data_d;
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign rom_rd_o    = rom_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = data_q;
  assign mem_wr_o    = mem_wr_q;
  assign last_word_o = (idx_q == LAST_IDX);
  assign chk_idx_o   = (idx_q == CHK_IDX);

`ifdef UP_STATE_CHECKSUM_EN
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic [CSUM_W-1:0] chk_sum;

  // data_q holds the word being written during BOOT_WR, so accumulate there.
  always_comb begin
    sum_d = sum_q;
    if (inc_i) begin
      sum_d = sum_q + data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  // In CHECK, data_q holds the checksum word read at idx = BOOT_WORDS.
  assign chk_sum  = sum_q + data_q;
  assign chk_ok_o = (chk_sum == '0);
`else
  assign chk_ok_o = 1'b1;
`endif

endmodule

// File: rtl/up_state_ctrl.sv
// uP state controller: copies the boot image into memory, releases the core,
// then serves pause/resume requests. UP_STATE_CHECKSUM_EN adds the image checksum.
module up_state_ctrl
  import up_state_pkg::*;
#(
  parameter int BOOT_WORDS = 32768
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_pauseReq,
  input  logic        i_resumeReq,
  output logic [15:0] o_romAddr,
  output logic        o_romRd,
  input  logic [15:0] i_romData,
  input  logic        i_romValid,
  output logic [15:0] o_memAddr,
  output logic [15:0] o_memDataOut,
  output logic        o_memWr,
  output logic        o_smIsBooted,
  output logic        o_smStartPause,
  input  logic        i_smNowPaused,
  output logic [2:0]  o_smState,
  output logic        o_bootErr
);

  up_state_e  state_q, state_d;
  logic       booted_q, booted_d;
  logic       start_q, start_d;
  logic [2:0] rpt_q, rpt_d;
  logic       err_q, err_d;

  logic rd_go, cap, wr_go, inc;
  logic last_word, chk_idx, chk_ok;

  // Pause handshake: o_smStartPause is a level held from PAUSING through
  // PAUSED; the core answers with i_smNowPaused, which tracks it one cycle
  // late, so the request is only dropped after an explicit resume and the
  // FSM returns to RUN once the acknowledge has actually fallen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = ST_BOOT_RD;
      ST_BOOT_RD:   state_d = ST_BOOT_WAIT;
      ST_BOOT_WAIT: if (i_romValid) state_d = chk_idx ? ST_CHECK : ST_BOOT_WR;
      ST_BOOT_WR:   state_d = (last_word && !CSUM_EN) ? ST_RUN : ST_BOOT_RD;
      ST_CHECK:     state_d = chk_ok ? ST_RUN : ST_ERROR;
      ST_RUN:       if (i_pauseReq) state_d = ST_PAUSING;
      ST_PAUSING:   if (i_smNowPaused) state_d = ST_PAUSED;
      ST_PAUSED:    if (i_resumeReq) state_d = ST_RESUMING;
      ST_RESUMING:  if (!i_smNowPaused) state_d = ST_RUN;
      ST_ERROR:     state_d = ST_ERROR;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered with it.
  always_comb begin
    booted_d = core_released(state_d);
    start_d  = pause_held(state_d);
    rpt_d    = report_state(state_d);
    err_d    = CSUM_EN && (state_d == ST_ERROR);
    rd_go    = (state_d == ST_BOOT_RD);
    wr_go    = (state_d == ST_BOOT_WR);
    cap      = (state_q == ST_BOOT_WAIT) && i_romValid;
    inc      = (state_q == ST_BOOT_WR);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      booted_q <= 1'b0;
      start_q  <= 1'b0;
      rpt_q    <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      booted_q <= booted_d;
      start_q  <= start_d;
      rpt_q    <= rpt_d;
      err_q    <= err_d;
    end
  end

  up_boot_copier #(
    .BOOT_WORDS (BOOT_WORDS)
  ) u_copier (
    .clk_i       (i_clk),
    .rst_ni      (i_rstn),
    .rd_go_i     (rd_go),
    .cap_i       (cap),
    .wr_go_i     (wr_go),
    .inc_i       (inc),
    .rom_data_i  (i_romData),
    .rom_addr_o  (o_romAddr),
    .rom_rd_o    (o_romRd),
    .mem_addr_o  (o_memAddr),
    .mem_data_o  (o_memDataOut),
    .mem_wr_o    (o_memWr),
    .last_word_o (last_word),
    .chk_idx_o   (chk_idx),
    .chk_ok_o    (chk_ok)
  );

  assign o_smIsBooted   = booted_q;
  assign o_smStartPause = start_q;
  assign o_smState      = rpt_q;
  assign o_bootErr      = err_q;

endmodule

// File: tb/tb_up_state_ctrl.sv
// Directed bench for up_state_ctrl: boot copy at two ROM latencies, pause and
// resume handshake, async reset mid-boot, and the checksum outcome when built in.
`timescale 1ns/1ps
module tb_up_state_ctrl;

  localparam int BW = 4;
`ifdef UP_STATE_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  // clock/reset and DUT signals
  logic        clk;
  logic        rst_n;
  logic        pause_req, resume_req;
  logic [15:0] rom_addr, rom_data, mem_addr, mem_data;
  logic        rom_rd, rom_valid, mem_wr;
  logic        booted, start_pause, now_paused, boot_err;
  logic [2:0]  sm_state;

  // bench state
  int          checks = 0;
  int          passes = 0;
  int          cyc, lat, rom_cnt, wr_seen;
  logic [15:0] rom_pend;
  bit          spurious;
  logic [15:0] image [0:BW];
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  up_state_ctrl #(
    .BOOT_WORDS (BW)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (rst_n),
    .i_pauseReq     (pause_req),
    .i_resumeReq    (resume_req),
    .o_romAddr      (rom_addr),
    .o_romRd        (rom_rd),
    .i_romData      (rom_data),
    .i_romValid     (rom_valid),
    .o_memAddr      (mem_addr),
    .o_memDataOut   (mem_data),
    .o_memWr        (mem_wr),
    .o_smIsBooted   (booted),
    .o_smStartPause (start_pause),
    .i_smNowPaused  (now_paused),
    .o_smState      (sm_state),
    .o_bootErr      (boot_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int boot_len(input int l);
    return 1 + BW * (2 + l) + (CS ? (2 + l) : 0);
  endfunction

  // Prepare model and scoreboard for a fresh boot; call while reset is held.
  task automatic arm(input int l, input bit sp);
    lat        = l;
    spurious   = sp;
    cyc        = 0;
    wr_seen    = 0;
    rom_cnt    = 0;
    rom_valid  = 1'b0;
    rom_data   = 16'h0;
    pause_req  = 1'b0;
    resume_req = 1'b0;
    now_paused = 1'b0;
    exp_q.delete();
    for (int k = 0; k < BW; k++) exp_q.push_back({16'(k), image[k]});
  endtask

  // One clock; sample #1 after the edge, then drive the ROM model and score writes.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    rom_valid = 1'b0;
    rom_data  = 16'h0;
    if (rom_cnt > 0) begin
      rom_cnt--;
      if (rom_cnt == 0) begin
        rom_valid = 1'b1;
        rom_data  = image[rom_pend];
      end
    end
    if (rom_rd) begin
      rom_cnt  = lat;
      rom_pend = rom_addr;
    end
    if (spurious && mem_wr) begin
      rom_valid = 1'b1;
      rom_data  = 16'hDEAD;
    end
    if (mem_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_wr), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[31:16]));
        chk("wr_data", 32'(mem_data), 32'(e[15:0]));
        chk("wr_cycle", cyc, (wr_seen + 1) * (2 + lat));
      end
      wr_seen++;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_rd", 32'(rom_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_booted", 32'(booted), 32'd0);
    chk("rst_start_pause", 32'(start_pause), 32'd0);
    chk("rst_state", 32'(sm_state), 32'd0);
    chk("rst_boot_err", 32'(boot_err), 32'd0);
  endtask

  task automatic boot(input int l, input bit sp);
    int n;
    rst_n = 1'b0;
    arm(l, sp);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = boot_len(l);
    repeat (n - 1) tick();
    chk("booted_early", 32'(booted), 32'd0);
    tick();
    chk("booted", 32'(booted), 32'd1);
    chk("run_state", 32'(sm_state), 32'd4);
    chk("boot_err_clear", 32'(boot_err), 32'd0);
    chk("write_count", wr_seen, BW);
    spurious = 1'b0;
  endtask

  initial begin
    int found;
    image[0] = 16'h1111;
    image[1] = 16'h2222;
    image[2] = 16'h3333;
    image[3] = 16'h4444;
    image[BW] = 16'h5556;  // 0xAAAA + 0x5556 = 0 mod 2^16
    rst_n = 1'b0;
    arm(1, 1'b0);
    repeat (2) @(negedge clk);
    chk_reset_vals();

    // Boot with L=1: writes at cycles 3,6,9,12; booted at 13 (16 with checksum).
    boot(1, 1'b0);

    // Pause / resume handshake from RUN.
    resume_req = 1'b1;
    tick();
    chk("resume_in_run", 32'(sm_state), 32'd4);
    chk("resume_in_run_sp", 32'(start_pause), 32'd0);
    resume_req = 1'b0;
    pause_req  = 1'b1;
    tick();
    chk("pausing", 32'(sm_state), 32'd5);
    chk("pausing_sp", 32'(start_pause), 32'd1);
    chk("pausing_booted", 32'(booted), 32'd1);
    pause_req  = 1'b0;
    resume_req = 1'b1;
    tick();
    chk("resume_in_pausing", 32'(sm_state), 32'd5);
    resume_req = 1'b0;
    now_paused = 1'b1;
    tick();
    chk("paused", 32'(sm_state), 32'd6);
    chk("paused_sp", 32'(start_pause), 32'd1);
    tick();
    chk("paused_hold", 32'(sm_state), 32'd6);
    resume_req = 1'b1;
    tick();
    chk("resuming", 32'(sm_state), 32'd7);
    chk("resuming_sp", 32'(start_pause), 32'd0);
    chk("resuming_booted", 32'(booted), 32'd1);
    resume_req = 1'b0;
    tick();
    chk("resuming_hold", 32'(sm_state), 32'd7);
    now_paused = 1'b0;
    tick();
    chk("back_to_run", 32'(sm_state), 32'd4);
    chk("back_to_run_sp", 32'(start_pause), 32'd0);

    // Boot with L=5 and spurious valid during BOOT_WR: writes every 7 cycles.
    boot(5, 1'b1);

    // Pause wins when both requests are high in RUN.
    pause_req  = 1'b1;
    resume_req = 1'b1;
    tick();
    chk("both_req_state", 32'(sm_state), 32'd5);
    chk("both_req_sp", 32'(start_pause), 32'd1);
    pause_req  = 1'b0;
    resume_req = 1'b0;

    // Async reset when the read of idx 2 is issued; reboot starts at address 0.
    rst_n = 1'b0;
    arm(1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (rom_rd && rom_addr == 16'd2) found = 1;
    end
    chk("mid_boot_reached", found, 1);
    chk("mid_boot_cycle", cyc, 7);
    rst_n = 1'b0;
    #2;
    chk_reset_vals();
    arm(1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reboot_rd", 32'(rom_rd), 32'd1);
    chk("reboot_addr", 32'(rom_addr), 32'd0);
    chk("reboot_state", 32'(sm_state), 32'd1);
    repeat (boot_len(1) - 2) tick();
    chk("reboot_early", 32'(booted), 32'd0);
    tick();
    chk("reboot_booted", 32'(booted), 32'd1);
    chk("reboot_writes", wr_seen, BW);

`ifdef UP_STATE_CHECKSUM_EN
    // Off-by-one checksum word ends in ERROR.
    image[BW] = 16'h5557;
    rst_n = 1'b0;
    arm(1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (boot_len(1)) tick();
    chk("err_flag", 32'(boot_err), 32'd1);
    chk("err_booted", 32'(booted), 32'd0);
    chk("err_state", 32'(sm_state), 32'd0);
    chk("err_writes", wr_seen, BW);
    tick();
    chk("err_sticky", 32'(boot_err), 32'd1);
    image[BW] = 16'h5556;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
